// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipe scroller.
//   col_state_t  - column generator state (gap columns / pipe columns)
//   lfsr_next    - 8-bit Fibonacci LFSR next state (taps 7,5,4,3)
//   gap_lo_calc  - lowest gap row for a pipe: 1 + (lfsr mod (rows-gap-1)),
//                  which keeps the gap clear of row 0 and row rows-1
package pipe_pkg;

  typedef enum logic [0:0] {
    GAP_COLS  = 1'b0,
    PIPE_COLS = 1'b1
  } col_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic int unsigned gap_lo_calc(input logic [7:0] s,
                                              input int unsigned rows,
                                              input int unsigned gap);
    return 32'd1 + (32'(s) % (rows - gap - 32'd1));
  endfunction

endpackage

// File: rtl/pipe_column_gen.sv
// pipe_column_gen: produces the next column to shift into the frame.
//   clk, reset : clock, asynchronous active-high reset
//   advance    : frame advances this cycle; steps the column FSM
//   restart    : synchronous clear of FSM and column counter (LFSR keeps running)
//   new_col    : column to insert at frame[0]; all zeros between pipes,
//                all ones except GAP rows starting at gap_lo inside a pipe
module pipe_column_gen
  import pipe_pkg::*;
#(
  parameter int unsigned ROWS    = 16,
  parameter int unsigned GAP     = 4,
  parameter int unsigned PIPE_W  = 2,
  parameter int unsigned SPACING = 6,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            restart,
  output logic [ROWS-1:0] new_col
);

  localparam int unsigned CNT_MAX = (PIPE_W > SPACING) ? PIPE_W : SPACING;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned GL_W    = $clog2(ROWS);

  logic [7:0]       lfsr;
  col_state_t       state;
  logic [CNT_W-1:0] col_cnt;
  logic [GL_W-1:0]  gap_lo;

  // Free-running: only reset reloads it, so restarts still see fresh gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= GAP_COLS;
      col_cnt <= '0;
      gap_lo  <= '0;
    end else if (restart) begin
      state   <= GAP_COLS;
      col_cnt <= '0;
    end else if (advance) begin
      case (state)
        GAP_COLS: begin
          if (col_cnt == CNT_W'(SPACING - 1)) begin
            gap_lo  <= GL_W'(gap_lo_calc(lfsr, ROWS, GAP));
            col_cnt <= '0;
            state   <= PIPE_COLS;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        PIPE_COLS: begin
          if (col_cnt == CNT_W'(PIPE_W - 1)) begin
            col_cnt <= '0;
            state   <= GAP_COLS;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        default: begin
          col_cnt <= '0;
          state   <= GAP_COLS;
        end
      endcase
    end
  end

  always_comb begin
    int unsigned lo;
    lo      = 32'(gap_lo);
    new_col = '0;
    if (state == PIPE_COLS) begin
      new_col = '1;
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (r >= lo && r < lo + GAP) new_col[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolling pipe obstacle field for the LED-matrix game.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : run scrolling; divider and frame hold while low
//   restart    : synchronous clear of frame, score, divider, step, pass
//   step_div   : clock cycles per scroll step (0 behaves as 1)
//   frame      : [COLS-1:0][ROWS-1:0] pixel map, index 0 = newest column
//   step       : one-cycle pulse with each newly shifted frame
//   pass       : one-cycle pulse when a pipe's trailing column leaves PASS_COL
//   score      : saturating count of passed pipes
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned GAP      = 4,
  parameter int unsigned PIPE_W   = 2,
  parameter int unsigned SPACING  = 6,
  parameter int unsigned PASS_COL = 12,
  parameter int unsigned DIV_W    = 24,
  parameter int unsigned SCORE_W  = 8,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [DIV_W-1:0]          step_div,
  output logic [COLS-1:0][ROWS-1:0] frame,
  output logic                      step,
  output logic                      pass,
  output logic [SCORE_W-1:0]        score
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_limit;
  logic             advance;
  logic             crossing;
  logic [ROWS-1:0]  new_col;

  // Equality compare only: a divider already past a lowered limit runs on
  // through the wrap before it matches again.
  always_comb begin
    div_limit = (step_div == '0) ? '0 : step_div - 1'b1;
    advance   = enable && (div_cnt == div_limit);
    crossing  = (frame[PASS_COL] != '0) && (frame[PASS_COL-1] == '0);
  end

  pipe_column_gen #(
    .ROWS    (ROWS),
    .GAP     (GAP),
    .PIPE_W  (PIPE_W),
    .SPACING (SPACING),
    .SEED    (SEED)
  ) u_colgen (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .restart (restart),
    .new_col (new_col)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      frame   <= '0;
      step    <= 1'b0;
      pass    <= 1'b0;
      score   <= '0;
    end else if (restart) begin
      div_cnt <= '0;
      frame   <= '0;
      step    <= 1'b0;
      pass    <= 1'b0;
      score   <= '0;
    end else begin
      step <= advance;
      pass <= advance && crossing;
      if (enable) begin
        div_cnt <= advance ? '0 : div_cnt + 1'b1;
      end
      if (advance) begin
        frame <= {frame[COLS-2:0], new_col};
        if (crossing && (score != '1)) score <= score + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: directed self-checking bench for pipe_scroller with
// default parameters, plus a SCORE_W=2 instance for score saturation.
module tb_pipe_scroller;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic restart = 1'b0;
  logic [23:0] step_div = 24'd1;

  logic [COLS-1:0][ROWS-1:0] frame, frame_s;
  logic       step, pass, step_s, pass_s;
  logic [7:0] score;
  logic [1:0] score_s;

  int passed = 0;
  int total  = 0;

  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  // Reference LFSR from the documented recurrence; reloads only on reset.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  pipe_scroller u_dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .restart  (restart),
    .step_div (step_div),
    .frame    (frame),
    .step     (step),
    .pass     (pass),
    .score    (score)
  );

  pipe_scroller #(.SCORE_W(2)) u_sat (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .restart  (restart),
    .step_div (step_div),
    .frame    (frame_s),
    .step     (step_s),
    .pass     (pass_s),
    .score    (score_s)
  );

  function automatic logic [15:0] pipe_col(input int g);
    logic [15:0] c;
    c = '1;
    for (int r = g; r < g + 4; r++) c[r] = 1'b0;
    return c;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    reset   = 1'b1;
    enable  = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (frame !== '0) $display("FAIL reset_frame: got %h expected 0", frame); else passed++;
    total++; if (step !== 1'b0) $display("FAIL reset_step: got %b expected 0", step); else passed++;
    total++; if (pass !== 1'b0) $display("FAIL reset_pass: got %b expected 0", pass); else passed++;
    total++; if (score !== 8'd0) $display("FAIL reset_score: got %0d expected 0", score); else passed++;
    total++; if (score_s !== 2'd0) $display("FAIL reset_score_sat: got %0d expected 0", score_s); else passed++;
    step_div = 24'd1;
    repeat (3) @(negedge clk);
    total++; if (frame !== '0) $display("FAIL disabled_frame: got %h expected 0", frame); else passed++;
  endtask

  task automatic test_pipe_entry;
    logic [7:0]  m;
    logic [15:0] exp;
    int g;
    g = 0;
    do_reset();
    step_div = 24'd1;
    enable   = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      m = m_lfsr;
      @(negedge clk);
      if ((i - 1) % 8 == 5) g = 1 + (m % 11);
      exp = ((i - 1) % 8 >= 6) ? pipe_col(g) : 16'h0000;
      total++; if (step !== 1'b1) $display("FAIL entry_step %0d: got %b expected 1", i, step); else passed++;
      total++; if (frame[0] !== exp) $display("FAIL entry_col %0d: got %h expected %h", i, frame[0], exp); else passed++;
    end
  endtask

  task automatic test_step_div;
    logic [COLS-1:0][ROWS-1:0] held;
    logic exp;
    do_reset();
    step_div = 24'd5;
    enable   = 1'b1;
    held     = frame;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      exp = (i % 5 == 0);
      total++; if (step !== exp) $display("FAIL div5_step %0d: got %b expected %b", i, step, exp); else passed++;
      if (!exp) begin
        total++; if (frame !== held) $display("FAIL div5_hold %0d: got %h expected %h", i, frame, held); else passed++;
      end else begin
        held = frame;
      end
    end
    step_div = 24'd0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++; if (step !== 1'b1) $display("FAIL div0_step %0d: got %b expected 1", i, step); else passed++;
    end
  endtask

  task automatic test_first_pass;
    int cnt;
    logic expp;
    cnt = 0;
    do_reset();
    step_div = 24'd1;
    enable   = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      expp = (i >= 21) && ((i - 21) % 8 == 0);
      if (expp) cnt++;
      total++; if (pass !== expp) $display("FAIL pass_pulse %0d: got %b expected %b", i, pass, expp); else passed++;
      total++; if (score !== 8'(cnt)) $display("FAIL pass_score %0d: got %0d expected %0d", i, score, cnt); else passed++;
    end
  endtask

  task automatic test_score_sat;
    int cnt;
    logic expp;
    cnt = 0;
    do_reset();
    step_div = 24'd1;
    enable   = 1'b1;
    for (int i = 1; i <= 56; i++) begin
      @(negedge clk);
      expp = (i >= 21) && ((i - 21) % 8 == 0);
      if (expp && cnt < 3) cnt++;
      total++; if (pass_s !== expp) $display("FAIL sat_pass %0d: got %b expected %b", i, pass_s, expp); else passed++;
      total++; if (score_s !== 2'(cnt)) $display("FAIL sat_score %0d: got %0d expected %0d", i, score_s, cnt); else passed++;
    end
  endtask

  task automatic test_enable_hold;
    logic [COLS-1:0][ROWS-1:0] held, exp_f;
    logic exp;
    do_reset();
    step_div = 24'd5;
    enable   = 1'b1;
    // 8 steps land on cycle 40; two more cycles leave the divider at 2.
    repeat (42) @(negedge clk);
    held = frame;
    total++; if (held[1:0] === '0) $display("FAIL hold_precond: got %h expected pipe columns", held[1:0]); else passed++;
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      total++; if (step !== 1'b0) $display("FAIL hold_step %0d: got %b expected 0", i, step); else passed++;
      total++; if (frame !== held) $display("FAIL hold_frame %0d: got %h expected %h", i, frame, held); else passed++;
    end
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp = (i == 3);
      total++; if (step !== exp) $display("FAIL resume_step %0d: got %b expected %b", i, step, exp); else passed++;
    end
    exp_f = {held[COLS-2:0], 16'h0000};
    total++; if (frame !== exp_f) $display("FAIL resume_frame: got %h expected %h", frame, exp_f); else passed++;
  endtask

  task automatic test_restart_advance;
    logic [7:0]  m;
    logic [15:0] exp;
    int g;
    g = 0;
    do_reset();
    step_div = 24'd1;
    enable   = 1'b1;
    repeat (22) @(negedge clk);
    total++; if (score !== 8'd1) $display("FAIL pre_restart_score: got %0d expected 1", score); else passed++;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    total++; if (frame !== '0) $display("FAIL restart_frame: got %h expected 0", frame); else passed++;
    total++; if (score !== 8'd0) $display("FAIL restart_score: got %0d expected 0", score); else passed++;
    total++; if (step !== 1'b0) $display("FAIL restart_step: got %b expected 0", step); else passed++;
    total++; if (pass !== 1'b0) $display("FAIL restart_pass: got %b expected 0", pass); else passed++;
    for (int i = 1; i <= 8; i++) begin
      m = m_lfsr;
      @(negedge clk);
      if (i == 6) g = 1 + (m % 11);
      exp = (i >= 7) ? pipe_col(g) : 16'h0000;
      total++; if (frame[0] !== exp) $display("FAIL restart_col %0d: got %h expected %h", i, frame[0], exp); else passed++;
    end
    // Asynchronous reset between clock edges, with a pipe on screen.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (frame !== '0) $display("FAIL async_frame: got %h expected 0", frame); else passed++;
    total++; if (step !== 1'b0) $display("FAIL async_step: got %b expected 0", step); else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      m = m_lfsr;
      @(negedge clk);
      if (i == 6) g = 1 + (m % 11);
      exp = (i >= 7) ? pipe_col(g) : 16'h0000;
      total++; if (frame[0] !== exp) $display("FAIL async_col %0d: got %h expected %h", i, frame[0], exp); else passed++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pipe_entry();
    test_step_div();
    test_first_pass();
    test_score_sat();
    test_enable_hold();
    test_restart_advance();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
